// File: rtl/bp_be_pkg.sv
// Shared issue-queue pointer type and circular pointer arithmetic.
// Pointers carry a wrap bit above an index field of up to iq_idx_w_max_lp bits.
package bp_be_pkg;

    localparam int unsigned iq_idx_w_max_lp = 16;

    typedef logic [iq_idx_w_max_lp:0] iq_lin_t;

    typedef struct packed {
        logic                       wrap;
        logic [iq_idx_w_max_lp-1:0] idx;
    } bp_be_iq_ptr_s;

    // Adds cnt to a pointer whose live index is idx_w bits wide, modulo 2^(idx_w+1).
    function automatic bp_be_iq_ptr_s iq_ptr_add(input bp_be_iq_ptr_s              ptr,
                                                 input logic [iq_idx_w_max_lp-1:0] cnt,
                                                 input int unsigned                idx_w);
        iq_lin_t       lin;
        iq_lin_t       idx_mask;
        bp_be_iq_ptr_s r;
        idx_mask = (iq_lin_t'(1) << idx_w) - iq_lin_t'(1);
        lin      = ({1'b0, ptr.idx} & idx_mask) | (iq_lin_t'(ptr.wrap) << idx_w);
        lin      = lin + {1'b0, cnt};
        r.wrap   = lin[idx_w];
        r.idx    = lin[iq_idx_w_max_lp-1:0] & idx_mask[iq_idx_w_max_lp-1:0];
        return r;
    endfunction

endpackage

// File: rtl/bp_be_iq_ptr.sv
// Circular queue pointer (wrap bit + index) with async active-low reset,
// a load path for clear/roll and an add path for normal advance.
module bp_be_iq_ptr
    import bp_be_pkg::*;
#(
    parameter int unsigned idx_w_p = 3,
    parameter int unsigned add_w_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_v_i,
    input  logic [idx_w_p:0]   load_ptr_i,
    input  logic [add_w_p-1:0] add_i,
    output logic [idx_w_p:0]   ptr_o
);

    logic [idx_w_p:0] ptr_q, ptr_d;
    bp_be_iq_ptr_s    cur, nxt;
    logic             unused_idx_hi;

    always_comb begin
        cur                   = '0;
        cur.wrap              = ptr_q[idx_w_p];
        cur.idx[idx_w_p-1:0]  = ptr_q[idx_w_p-1:0];
        nxt                   = iq_ptr_add(cur, iq_idx_w_max_lp'(add_i), idx_w_p);
        ptr_d                 = load_v_i ? load_ptr_i : {nxt.wrap, nxt.idx[idx_w_p-1:0]};
    end

    assign unused_idx_hi = ^nxt.idx[iq_idx_w_max_lp-1:idx_w_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bp_be_issue_queue_mw.sv
// Multi-wide checkpointed issue queue: write, speculative read and commit pointers.
// Optional BP_BE_ISSUE_QUEUE_BYPASS_EN presents an enqueue on an empty queue in the same cycle.
module bp_be_issue_queue_mw
    import bp_be_pkg::*;
#(
    parameter int unsigned width_p       = 64,
    parameter int unsigned els_p         = 8,
    parameter int unsigned issue_width_p = 2
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 clr_v_i,
    input  logic                                 roll_v_i,
    input  logic                                 suppress_v_i,
    input  logic                                 enq_v_i,
    input  logic [width_p-1:0]                   enq_data_i,
    output logic                                 enq_ready_and_o,
    input  logic [$clog2(issue_width_p+1)-1:0]   read_cnt_i,
    input  logic [$clog2(issue_width_p+1)-1:0]   deq_cnt_i,
    output logic [issue_width_p-1:0]             issue_v_o,
    output logic [issue_width_p*width_p-1:0]     issue_data_o,
    output logic [$clog2(els_p+1)-1:0]           count_o
);

    localparam int unsigned idx_w_lp = $clog2(els_p);
    localparam int unsigned ptr_w_lp = idx_w_lp + 1;
    localparam int unsigned cnt_w_lp = $clog2(issue_width_p+1);

    logic [ptr_w_lp-1:0] wptr, rptr, cptr, cptr_n;
    logic [ptr_w_lp-1:0] occ, avail, inflight;
    logic                full, enq_ack;
    logic [width_p-1:0]  mem_q [els_p];
    logic [width_p-1:0]  mem_d [els_p];

    assign occ      = wptr - cptr;
    assign avail    = wptr - rptr;
    assign inflight = rptr - cptr;
    assign full     = (occ == ptr_w_lp'(els_p));
    assign count_o  = occ;
    assign cptr_n   = cptr + ptr_w_lp'(deq_cnt_i);

    // Ready is held low during reset and uses only registered pointers.
    assign enq_ready_and_o = reset_n_i & ~full & ~suppress_v_i & ~clr_v_i;
    assign enq_ack         = enq_v_i & enq_ready_and_o;

    bp_be_iq_ptr #(.idx_w_p(idx_w_lp), .add_w_p(1)) wptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .load_v_i(clr_v_i), .load_ptr_i('0),
        .add_i(enq_ack), .ptr_o(wptr)
    );

    bp_be_iq_ptr #(.idx_w_p(idx_w_lp), .add_w_p(cnt_w_lp)) rptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .load_v_i(clr_v_i | roll_v_i), .load_ptr_i(clr_v_i ? '0 : cptr_n),
        .add_i(read_cnt_i), .ptr_o(rptr)
    );

    bp_be_iq_ptr #(.idx_w_p(idx_w_lp), .add_w_p(cnt_w_lp)) cptr_reg (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .load_v_i(clr_v_i), .load_ptr_i('0),
        .add_i(deq_cnt_i), .ptr_o(cptr)
    );

    always_comb begin
        mem_d = mem_q;
        if (enq_ack) mem_d[wptr[idx_w_lp-1:0]] = enq_data_i;
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        issue_v_o    = '0;
        issue_data_o = '0;
        for (int i = 0; i < int'(issue_width_p); i++) begin
            issue_v_o[i]                     = (avail > ptr_w_lp'(i)) & ~suppress_v_i;
            issue_data_o[i*width_p+:width_p] = mem_q[rptr[idx_w_lp-1:0] + idx_w_lp'(i)];
        end
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        if ((avail == '0) && enq_ack) begin
            issue_v_o[0]             = 1'b1;
            issue_data_o[0+:width_p] = enq_data_i;
        end
`endif
    end

    read_cnt_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (!clr_v_i && !roll_v_i) |-> (int'(read_cnt_i) <= $countones(issue_v_o)));

    deq_cnt_legal_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !clr_v_i |-> (ptr_w_lp'(deq_cnt_i) <= inflight));

endmodule

// File: tb/tb_bp_be_issue_queue_mw.sv
// Directed bench for bp_be_issue_queue_mw (width 64, depth 8, issue width 2).
module tb_bp_be_issue_queue_mw;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic         clr_v_i, roll_v_i, suppress_v_i, enq_v_i;
    logic [63:0]  enq_data_i;
    logic         enq_ready_and_o;
    logic [1:0]   read_cnt_i, deq_cnt_i;
    logic [1:0]   issue_v_o;
    logic [127:0] issue_data_o;
    logic [3:0]   count_o;

    int n_checks = 0;
    int n_errors = 0;

    bp_be_issue_queue_mw #(.width_p(64), .els_p(8), .issue_width_p(2)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .clr_v_i(clr_v_i), .roll_v_i(roll_v_i),
        .suppress_v_i(suppress_v_i), .enq_v_i(enq_v_i), .enq_data_i(enq_data_i),
        .enq_ready_and_o(enq_ready_and_o), .read_cnt_i(read_cnt_i), .deq_cnt_i(deq_cnt_i),
        .issue_v_o(issue_v_o), .issue_data_o(issue_data_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        clr_v_i = 0; roll_v_i = 0; suppress_v_i = 0; enq_v_i = 0;
        enq_data_i = '0; read_cnt_i = 0; deq_cnt_i = 0;
    endtask

    task automatic enq(input logic [63:0] d);
        enq_v_i = 1; enq_data_i = d;
        tick();
        enq_v_i = 0;
    endtask

    task automatic clear();
        clr_v_i = 1;
        tick();
        clr_v_i = 0;
    endtask

    initial begin
        idle();
        reset_n_i = 0;
        repeat (2) tick();
        check("rst_count", count_o, 0);
        check("rst_issue_v", issue_v_o, 0);
        check("rst_ready", enq_ready_and_o, 0);
        reset_n_i = 1;
        #1;
        check("rel_ready", enq_ready_and_o, 1);

        // reset mid-traffic
        enq(64'h11); enq(64'h12); enq(64'h13);
        #1;
        check("t1_count", count_o, 3);
        check("t1_issue_v", issue_v_o, 2'b11);
        #1 reset_n_i = 0;
        #1;
        check("t1_rst_issue_v", issue_v_o, 0);
        check("t1_rst_count", count_o, 0);
        tick();
        reset_n_i = 1;
        #1;
        check("t1_rel_ready", enq_ready_and_o, 1);

        // fill
        for (int i = 0; i < 8; i++) enq(64'd100 + 64'(i));
        enq_v_i = 1;
        #1;
        check("t2_count", count_o, 8);
        check("t2_full_ready", enq_ready_and_o, 0);
        enq_v_i = 0;
        check("t2_slot0", issue_data_o[63:0], 64'd100);
        check("t2_slot1", issue_data_o[127:64], 64'd101);
        read_cnt_i = 2;
        tick();
        read_cnt_i = 0; deq_cnt_i = 2;
        #1;
        check("t2_deq_same_ready", enq_ready_and_o, 0);
        tick();
        deq_cnt_i = 0;
        #1;
        check("t2_deq_next_ready", enq_ready_and_o, 1);
        check("t2_deq_count", count_o, 6);

        // clear with simultaneous enqueue
        clr_v_i = 1; enq_v_i = 1; enq_data_i = 64'hDEAD;
        #1;
        check("t5_clr_ready", enq_ready_and_o, 0);
        tick();
        idle();
        #1;
        check("t5_count", count_o, 0);
        check("t5_issue_v", issue_v_o, 0);

        // walk all pointers to 7
        for (int i = 0; i < 7; i++) enq(64'h50 + 64'(i));
        read_cnt_i = 2;                 tick();
        read_cnt_i = 2; deq_cnt_i = 2;  tick();
        read_cnt_i = 2; deq_cnt_i = 2;  tick();
        read_cnt_i = 1; deq_cnt_i = 2;  tick();
        read_cnt_i = 0; deq_cnt_i = 1;  tick();
        deq_cnt_i = 0;
        #1;
        check("t3_pre_count", count_o, 0);
        check("t3_pre_issue_v", issue_v_o, 0);

        // wide read across the wrap
        enq(64'hA); enq(64'hB); enq(64'hC);
        #1;
        check("t3_count", count_o, 3);
        check("t3_issue_v", issue_v_o, 2'b11);
        check("t3_slot0", issue_data_o[63:0], 64'hA);
        check("t3_slot1", issue_data_o[127:64], 64'hB);
        read_cnt_i = 2;
        tick();
        read_cnt_i = 0;
        #1;
        check("t3_after_slot0", issue_data_o[63:0], 64'hC);
        check("t3_after_issue_v", issue_v_o, 2'b01);
        clear();

        // roll with commit and enqueue in the same cycle
        enq(64'hA0); enq(64'hB0); enq(64'hC0); enq(64'hD0);
        read_cnt_i = 2; tick();
        read_cnt_i = 1; tick();
        read_cnt_i = 0;
        #1;
        check("t4_pre_issue_v", issue_v_o, 2'b01);
        check("t4_pre_slot0", issue_data_o[63:0], 64'hD0);
        roll_v_i = 1; deq_cnt_i = 1; enq_v_i = 1; enq_data_i = 64'hE0;
        tick();
        idle();
        #1;
        check("t4_issue_v", issue_v_o, 2'b11);
        check("t4_slot0", issue_data_o[63:0], 64'hB0);
        check("t4_slot1", issue_data_o[127:64], 64'hC0);
        check("t4_count", count_o, 4);
        clear();

        // suppress
        enq(64'h21); enq(64'h22);
        suppress_v_i = 1; enq_v_i = 1; enq_data_i = 64'h23;
        #1;
        check("t6_sup_issue_v", issue_v_o, 0);
        check("t6_sup_ready", enq_ready_and_o, 0);
        tick();
        idle();
        #1;
        check("t6_sup_count", count_o, 2);
        check("t6_sup_after_v", issue_v_o, 2'b11);
        check("t6_sup_after_d0", issue_data_o[63:0], 64'h21);
        clear();

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        enq_v_i = 1; enq_data_i = 64'hFACE; read_cnt_i = 1;
        #1;
        check("t6_byp_v", issue_v_o, 2'b01);
        check("t6_byp_d0", issue_data_o[63:0], 64'hFACE);
        tick();
        idle();
        #1;
        check("t6_byp_count", count_o, 1);
        check("t6_byp_after_v", issue_v_o, 0);
`else
        enq_v_i = 1; enq_data_i = 64'hFACE;
        #1;
        check("t6_nobyp_v", issue_v_o, 0);
        tick();
        idle();
        #1;
        check("t6_nobyp_after_v", issue_v_o, 2'b01);
        check("t6_nobyp_d0", issue_data_o[63:0], 64'hFACE);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
